// File: rtl/myproject_acc_48s_requant.sv
// Streaming accumulator + requantizer: sums LEN signed products, then
// rounds half-up, arithmetic-shifts and saturates to a signed OUT_WIDTH result.
module myproject_acc_48s_requant #(
  parameter int unsigned PROD_WIDTH = 48,
  parameter int unsigned LEN        = 16,
  parameter int unsigned ACC_WIDTH  = 56,
  parameter int unsigned FRAC_SHIFT = 16,
  parameter int unsigned OUT_WIDTH  = 24
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat
);

  localparam int unsigned CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
  localparam int unsigned EXT_W = ACC_WIDTH + 1;
  localparam int unsigned SGN_W = ACC_WIDTH - PROD_WIDTH;
  localparam int unsigned TOP_W = EXT_W - OUT_WIDTH + 1;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [EXT_W-1:0]     RND_HALF = EXT_W'(1) << (FRAC_SHIFT - 1);
  localparam logic [OUT_WIDTH-1:0] SAT_HI   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_LO   = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_ROUND = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;

  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [EXT_W-1:0]       rnd_sum;
  logic signed [EXT_W-1:0] rnd_shr;
  logic [TOP_W-1:0]       rnd_top;
  logic                   rnd_fits;
  logic                   beat;

  // Rounding datapath: one guard bit above the accumulator keeps the +half from wrapping.
  always_comb begin
    prod_ext = {{SGN_W{in_data[PROD_WIDTH-1]}}, in_data};
    rnd_sum  = {acc_q[ACC_WIDTH-1], acc_q} + RND_HALF;
    rnd_shr  = $signed(rnd_sum) >>> FRAC_SHIFT;
    rnd_top  = rnd_shr[EXT_W-1:OUT_WIDTH-1];
    rnd_fits = (&rnd_top) | ~(|rnd_top);
    beat     = in_valid & in_ready_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      ST_ACC: begin
        if (beat) begin
          acc_d = (cnt_q == '0) ? prod_ext : (acc_q + prod_ext);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_ROUND;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ROUND: begin
        if (rnd_fits) begin
          out_data_d = rnd_shr[OUT_WIDTH-1:0];
          out_sat_d  = 1'b0;
        end else begin
          out_data_d = rnd_shr[EXT_W-1] ? SAT_LO : SAT_HI;
          out_sat_d  = 1'b1;
        end
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d     = ST_ACC;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == ST_ACC);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_myproject_acc_48s_requant.sv
// Directed bench for myproject_acc_48s_requant with LEN=4, FRAC_SHIFT=16, OUT_WIDTH=24.
module tb_myproject_acc_48s_requant;

  localparam int unsigned PW = 48;
  localparam int unsigned OW = 24;

  logic          ap_clk    = 1'b0;
  logic          ap_rst_n  = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_sat;

  int n_chk  = 0;
  int n_pass = 0;

  myproject_acc_48s_requant #(
    .PROD_WIDTH(48), .LEN(4), .ACC_WIDTH(56), .FRAC_SHIFT(16), .OUT_WIDTH(24)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one product starting at a falling edge; returns at the falling edge after acceptance.
  task automatic beat(input logic [PW-1:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(negedge ap_clk);
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send4(input logic [PW-1:0] a, input logic [PW-1:0] b,
                       input logic [PW-1:0] c, input logic [PW-1:0] d);
    beat(a);
    beat(b);
    beat(c);
    beat(d);
  endtask

  // Called at the falling edge right after the last accept: ROUND cycle, then HOLD.
  task automatic result(input string tag, input logic [OW-1:0] ed, input logic es, input int stall);
    out_ready = (stall == 0);
    chk({tag, "_round_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_round_rdy"},   64'(in_ready),  64'd0);
    @(negedge ap_clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data),  64'(ed));
    chk({tag, "_sat"},   64'(out_sat),   64'(es));
    chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge ap_clk);
      chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_stall_data"},  64'(out_data),  64'(ed));
      chk({tag, "_stall_sat"},   64'(out_sat),   64'(es));
      chk({tag, "_stall_rdy"},   64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_done_rdy"},   64'(in_ready),  64'd1);
    out_ready = 1'b0;
  endtask

  logic [PW-1:0] rnd_in  [4];
  logic [OW-1:0] rnd_exp [4];
  logic          bub_pat [7];

  initial begin
    rnd_in[0] = 48'h0000_0000_8000; rnd_exp[0] = 24'h000001;
    rnd_in[1] = 48'h0000_0000_7FFF; rnd_exp[1] = 24'h000000;
    rnd_in[2] = 48'hFFFF_FFFF_8000; rnd_exp[2] = 24'h000000;
    rnd_in[3] = 48'hFFFF_FFFF_7FFF; rnd_exp[3] = 24'hFFFFFF;
    bub_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge ap_clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_sat",   64'(out_sat),   64'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rst_rdy", 64'(in_ready), 64'd1);

    // Basic sum with out_ready high throughout
    out_ready = 1'b1;
    send4(48'h1_0000, 48'h1_0000, 48'h1_0000, 48'h1_0000);
    result("basic", 24'd4, 1'b0, 0);

    // Round-half-up cases
    for (int k = 0; k < 4; k++) begin
      send4(rnd_in[k], 48'h0, 48'h0, 48'h0);
      result($sformatf("round%0d", k), rnd_exp[k], 1'b0, 0);
    end

    // Input bubbles: values 1..4 <<16 on the valid slots
    begin
      int idx = 1;
      for (int c = 0; c < 7; c++) begin
        in_valid = bub_pat[c];
        in_data  = bub_pat[c] ? (PW'(idx) << 16) : 48'hDEAD_BEEF_0000;
        if (bub_pat[c]) begin
          chk("bubble_rdy", 64'(in_ready), 64'd1);
          idx++;
        end
        @(negedge ap_clk);
      end
      in_valid = 1'b0;
      result("bubble", 24'd10, 1'b0, 0);
    end

    // Backpressure for 5 cycles
    send4(48'h3_0000, 48'h3_0000, 48'h3_0000, 48'h3_0000);
    result("bp", 24'd12, 1'b0, 5);

    // Saturation both ways
    send4(48'h7FFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFF);
    result("sat_pos", 24'h7FFFFF, 1'b1, 0);
    send4(48'h8000_0000_0000, 48'h8000_0000_0000, 48'h8000_0000_0000, 48'h8000_0000_0000);
    result("sat_neg", 24'h800000, 1'b1, 0);

    // Asynchronous reset after 2 of 4 beats
    beat(48'h7FFF_FFFF_FFFF);
    beat(48'h7FFF_FFFF_FFFF);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
    chk("mid_rst_sat",   64'(out_sat),   64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_rdy", 64'(in_ready), 64'd1);
    send4(48'h1_0000, 48'h1_0000, 48'h1_0000, 48'h1_0000);
    result("post_rst", 24'd4, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d so far)", n_pass, n_chk);
    $fatal(1);
  end

endmodule
